// File: rtl/dm_lsu_pkg.sv
// Shared data-memory definitions: access-size encodings (also used by the control
// decoder), LSU FSM state encodings, default bus timeout and the alignment check.
package dm_pkg;

    localparam int unsigned DM_TIMEOUT = 255;

    typedef enum logic [2:0] {
        DM_WORD   = 3'b000,
        DM_HALF   = 3'b001,
        DM_HALF_U = 3'b010,
        DM_BYTE   = 3'b011,
        DM_BYTE_U = 3'b100
    } dm_type_e;

    // Fixed encodings kept as plain constants for legacy consumers; the enum reuses them.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_REQ  = ST_REQ,
        S_DONE = ST_DONE
    } dm_state_e;

    function automatic logic dm_legal(input logic [2:0] t, input logic [1:0] a);
        case (t)
            DM_WORD:            return (a == 2'b00);
            DM_HALF, DM_HALF_U: return !a[0];
            DM_BYTE, DM_BYTE_U: return 1'b1;
            default:            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dm_lsu_if.sv
// Word-oriented data bus between the LSU (master) and the memory responder (slave).
interface dm_lsu_if;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/dm_lsu_lane_fmt.sv
// Combinational lane formatting: byte enables, store replication, load extract/extend.
module dm_lane_fmt
    import dm_pkg::*;
(
    input  logic [2:0]  dm_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] bus_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        half_sel = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (addr_lo)
            2'b00:   byte_sel = bus_rdata[7:0];
            2'b01:   byte_sel = bus_rdata[15:8];
            2'b10:   byte_sel = bus_rdata[23:16];
            default: byte_sel = bus_rdata[31:24];
        endcase
    end

    always_comb begin
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = bus_rdata;
        case (dm_type)
            DM_HALF, DM_HALF_U: begin
                be         = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = (dm_type == DM_HALF) ? {{16{half_sel[15]}}, half_sel}
                                                  : {16'h0000, half_sel};
            end
            DM_BYTE, DM_BYTE_U: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = (dm_type == DM_BYTE) ? {{24{byte_sel[7]}}, byte_sel}
                                                  : {24'h000000, byte_sel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_lsu.sv
// Data-memory load/store unit: single outstanding bus access with stall, timeout
// abort and same-cycle rejection of misaligned or malformed requests.
module dm_lsu
    import dm_pkg::*;
#(
    parameter int unsigned TIMEOUT = DM_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  dm_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    dm_lsu_if.master    bus
);

    dm_state_e   state_q;
    logic [7:0]  cnt_q;
    logic [2:0]  type_q;
    logic [1:0]  alo_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wd_q;

    logic        access;
    logic        legal;
    logic        in_idle;
    logic        illegal_now;
    logic        timeout_hit;
    logic [2:0]  fmt_type;
    logic [1:0]  fmt_alo;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_wdata;
    logic [31:0] fmt_rdata;

    // One formatter serves both phases: live inputs in IDLE, latched size/offset in REQ.
    dm_lane_fmt u_fmt (
        .dm_type    (fmt_type),
        .addr_lo    (fmt_alo),
        .wdata      (wdata),
        .bus_rdata  (bus.bus_rdata),
        .be         (fmt_be),
        .wdata_lane (fmt_wdata),
        .rdata_ext  (fmt_rdata)
    );

    always_comb begin
        access      = mem_read | mem_write;
        legal       = !(mem_read & mem_write) && dm_legal(dm_type, addr[1:0]);
        in_idle     = (state_q == S_IDLE);
        fmt_type    = in_idle ? dm_type : type_q;
        fmt_alo     = in_idle ? addr[1:0] : alo_q;
        illegal_now = !rst && in_idle && access && !legal;
        timeout_hit = (cnt_q == 8'(TIMEOUT - 1));
        stall       = !rst && ((in_idle && access && legal) || (state_q == S_REQ));
        done        = illegal_now || (!rst && (state_q == S_DONE));
        err         = illegal_now || (!rst && (state_q == S_DONE) && err_q);
        rdata       = (state_q == S_DONE) ? rdata_q : '0;
    end

    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            type_q  <= '0;
            alo_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wd_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (access && legal) begin
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                        we_q    <= mem_write;
                        addr_q  <= {addr[31:2], 2'b00};
                        be_q    <= fmt_be;
                        wd_q    <= fmt_wdata;
                        type_q  <= dm_type;
                        alo_q   <= addr[1:0];
                        cnt_q   <= '0;
                    end
                end
                S_REQ: begin
                    // Ack is checked first so a response on the last allowed cycle still succeeds.
                    if (bus.bus_ack) begin
                        state_q <= S_DONE;
                        req_q   <= 1'b0;
                        rdata_q <= we_q ? '0 : fmt_rdata;
                        err_q   <= 1'b0;
                    end else if (timeout_hit) begin
                        state_q <= S_DONE;
                        req_q   <= 1'b0;
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_lsu.sv
// Scoreboard bench for dm_lsu: directed accesses queue expected completions and bus
// transactions; a monitor checks them whenever done or bus_req is presented.
module tb_dm_lsu;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } txn_t;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  dm_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        err;

    int n_cmp;
    int n_bad;

    resp_t exp_q[$];
    txn_t  bus_q[$];

    dm_lsu_if bus ();

    dm_lsu #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .dm_type   (dm_type),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .done      (done),
        .err       (err),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endfunction

    // Monitor: completion pulses against exp_q, bus transactions against bus_q.
    initial begin
        resp_t r;
        txn_t  cur;
        bit    in_txn;
        in_txn = 1'b0;
        forever begin
            @(negedge clk);
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1 rdata %h, required no completion", rdata);
                end else begin
                    r = exp_q.pop_front();
                    chk("done_rdata", rdata, r.rdata);
                    chk("done_err", 32'(err), 32'(r.err));
                end
            end
            if (bus.bus_req) begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    if (bus_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_bus_req: got bus_req=1 addr %h, required idle bus", bus.bus_addr);
                        cur = '{bus.bus_we, bus.bus_addr, bus.bus_be, bus.bus_wdata};
                    end else begin
                        cur = bus_q.pop_front();
                    end
                end
                chk("bus_we", 32'(bus.bus_we), 32'(cur.we));
                chk("bus_addr", bus.bus_addr, cur.addr);
                chk("bus_be", 32'(bus.bus_be), 32'(cur.be));
                chk("bus_wdata", bus.bus_wdata, cur.wdata);
            end else begin
                in_txn = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after the done pulse.
    task automatic do_access(input string nm, input logic rd, input logic wr,
                             input logic [2:0] t, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] brd,
                             input int ack_at, input int exp_reqs,
                             input logic [31:0] exp_rdata, input logic exp_err,
                             input logic [3:0] exp_be, input logic [31:0] exp_bwd);
        int    stalls, reqs, cycles, ridx;
        int    exp_stalls, exp_cycles;
        bit    fin;
        resp_t r;
        txn_t  tx;
        stalls = 0; reqs = 0; cycles = 0; ridx = 0; fin = 1'b0;
        exp_stalls = (exp_reqs > 0) ? exp_reqs + 1 : 0;
        exp_cycles = (exp_reqs > 0) ? exp_reqs + 2 : 1;
        r.rdata = exp_rdata;
        r.err   = exp_err;
        exp_q.push_back(r);
        if (exp_reqs > 0) begin
            tx.we    = wr;
            tx.addr  = {a[31:2], 2'b00};
            tx.be    = exp_be;
            tx.wdata = exp_bwd;
            bus_q.push_back(tx);
        end
        mem_read = rd; mem_write = wr; dm_type = t; addr = a; wdata = wd;
        bus.bus_rdata = brd;
        bus.bus_ack   = 1'b0;
        while (!fin && cycles < 300) begin
            if (bus.bus_req) begin
                bus.bus_ack = (ridx == ack_at);
                ridx++;
            end else begin
                bus.bus_ack = 1'b0;
            end
            @(negedge clk);
            if (stall) stalls++;
            if (bus.bus_req) reqs++;
            if (done) fin = 1'b1;
            cycles++;
            @(posedge clk); #1;
        end
        mem_read = 1'b0; mem_write = 1'b0; bus.bus_ack = 1'b0;
        chk({nm, "_done_seen"}, 32'(fin), 32'd1);
        chk({nm, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
        chk({nm, "_req_cycles"}, 32'(reqs), 32'(exp_reqs));
        chk({nm, "_latency"}, 32'(cycles), 32'(exp_cycles));
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; mem_read = 1'b1; mem_write = 1'b0; dm_type = 3'b000;
        addr = '0; wdata = '0; bus.bus_ack = 1'b0; bus.bus_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; mem_read = 1'b0;
        @(negedge clk);
        chk("rst_bus_req", 32'(bus.bus_req), 32'd0);
        chk("rst_bus_we", 32'(bus.bus_we), 32'd0);
        chk("rst_bus_addr", bus.bus_addr, 32'd0);
        chk("rst_bus_be", 32'(bus.bus_be), 32'd0);
        chk("rst_bus_wdata", bus.bus_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        @(posedge clk); #1;

        //        name      rd    wr    type    addr          wdata         bus_rdata     ack reqs exp_rdata     err   be       bus_wdata
        do_access("lb103",  1'b1, 1'b0, 3'b011, 32'h103, 32'h0,        32'h80FF_1234,  0, 1, 32'hFFFF_FF80, 1'b0, 4'b1000, 32'h0);
        do_access("sh202",  1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 32'h0,         0, 1, 32'h0,         1'b0, 4'b1100, 32'hABCD_ABCD);
        do_access("lw101",  1'b1, 1'b0, 3'b000, 32'h101, 32'h0,        32'hFFFF_FFFF,  0, 0, 32'h0,         1'b1, 4'b0000, 32'h0);
        do_access("lhu_to", 1'b1, 1'b0, 3'b010, 32'h002, 32'h0,        32'hFFFF_FFFF, -1, 4, 32'h0,         1'b1, 4'b1100, 32'h0);

        // Reset in the second REQ cycle, late ack afterwards: aborted silently.
        bus_q.push_back('{1'b0, 32'h0, 4'b0010, 32'h0});
        mem_read = 1'b1; dm_type = 3'b100; addr = 32'h001; wdata = '0;
        bus.bus_rdata = 32'h0000_AA00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstreq_stall", 32'(stall), 32'd0);
        chk("rstreq_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; mem_read = 1'b0; bus.bus_ack = 1'b1;
        @(negedge clk);
        chk("rstreq_bus_req", 32'(bus.bus_req), 32'd0);
        chk("rstreq_done_late", 32'(done), 32'd0);
        chk("rstreq_stall_idle", 32'(stall), 32'd0);
        @(posedge clk); #1;
        bus.bus_ack = 1'b0;
        @(negedge clk);
        chk("rstreq_bus_req2", 32'(bus.bus_req), 32'd0);
        chk("rstreq_done2", 32'(done), 32'd0);
        @(posedge clk); #1;

        do_access("sw10",   1'b0, 1'b1, 3'b000, 32'h010, 32'hDEAD_BEEF, 32'h0,          1, 2, 32'h0,         1'b0, 4'b1111, 32'hDEAD_BEEF);
        do_access("lw10",   1'b1, 1'b0, 3'b000, 32'h010, 32'h0,        32'h1234_5678,  0, 1, 32'h1234_5678, 1'b0, 4'b1111, 32'h0);
        do_access("lh002",  1'b1, 1'b0, 3'b001, 32'h002, 32'h0,        32'h8001_7FFF,  0, 1, 32'hFFFF_8001, 1'b0, 4'b1100, 32'h0);
        do_access("lh000",  1'b1, 1'b0, 3'b001, 32'h000, 32'h0,        32'h8001_7FFF,  0, 1, 32'h0000_7FFF, 1'b0, 4'b0011, 32'h0);
        do_access("lbu102", 1'b1, 1'b0, 3'b100, 32'h102, 32'h0,        32'h80FF_1234,  0, 1, 32'h0000_00FF, 1'b0, 4'b0100, 32'h0);
        do_access("lb100",  1'b1, 1'b0, 3'b011, 32'h100, 32'h0,        32'h0000_007F,  0, 1, 32'h0000_007F, 1'b0, 4'b0001, 32'h0);
        do_access("sb001",  1'b0, 1'b1, 3'b011, 32'h001, 32'h1234_56A5, 32'h0,         0, 1, 32'h0,         1'b0, 4'b0010, 32'hA5A5_A5A5);
        do_access("rdwr",   1'b1, 1'b1, 3'b000, 32'h040, 32'h0,        32'h1111_1111,  0, 0, 32'h0,         1'b1, 4'b0000, 32'h0);
        do_access("type5",  1'b1, 1'b0, 3'b101, 32'h040, 32'h0,        32'h1111_1111,  0, 0, 32'h0,         1'b1, 4'b0000, 32'h0);
        do_access("lh003",  1'b1, 1'b0, 3'b001, 32'h003, 32'h0,        32'h1111_1111,  0, 0, 32'h0,         1'b1, 4'b0000, 32'h0);
        do_access("sh201",  1'b0, 1'b1, 3'b001, 32'h201, 32'h0000_1234, 32'h0,         0, 0, 32'h0,         1'b1, 4'b0000, 32'h0);
        do_access("ack_tie", 1'b1, 1'b0, 3'b000, 32'h020, 32'h0,       32'hCAFE_F00D,  3, 4, 32'hCAFE_F00D, 1'b0, 4'b1111, 32'h0);

        // Stray ack with no access in flight must not start or complete anything.
        bus.bus_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_ack_bus_req", 32'(bus.bus_req), 32'd0);
            chk("idle_ack_stall", 32'(stall), 32'd0);
            @(posedge clk); #1;
        end
        bus.bus_ack = 1'b0;

        repeat (2) @(posedge clk);
        chk("resp_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
